// File: rtl/if_id_fifo.sv
// IF/ID decoupling queue: DEPTH-entry FIFO of (address, instruction) pairs between
// fetch and decode, with valid/ready on both sides and a flush for taken jumps.
module if_id_fifo #(
    parameter int              AW    = 32,
    parameter int              IW    = 32,
    parameter int              DEPTH = 4,
    parameter logic [IW-1:0]   NOP   = IW'(32'h0000_0013)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AW-1:0]              inst_addr_i,
    input  logic [IW-1:0]              inst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic                       flush_i,
    output logic [AW-1:0]              inst_addr_o,
    output logic [IW-1:0]              inst_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   PTR_ONE  = (PW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]    r_wp;
    logic [PW:0]    r_rp;
    logic [AW-1:0]  r_addr_mem [DEPTH];
    logic [IW-1:0]  r_inst_mem [DEPTH];

    logic [PW:0]    w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;

    assign w_count = r_wp - r_rp;
    assign w_full  = (w_count == FULL_CNT);
    assign w_empty = (w_count == '0);

    // ready_o depends only on registered state, so a pop never frees a slot in the same cycle.
    assign w_push  = valid_i & ~w_full & ~flush_i;
    assign w_pop   = ~w_empty & ready_i & ~flush_i;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else if (flush_i) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PTR_ONE;
            if (w_pop)  r_rp <= r_rp + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; empty-queue outputs are masked, so its contents never leak.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wp[PW-1:0]] <= inst_addr_i;
            r_inst_mem[r_wp[PW-1:0]] <= inst_i;
        end
    end

    assign ready_o     = ~w_full;
    assign valid_o     = ~w_empty;
    assign count_o     = w_count;
    assign inst_o      = w_empty ? NOP : r_inst_mem[r_rp[PW-1:0]];
    assign inst_addr_o = w_empty ? '0  : r_addr_mem[r_rp[PW-1:0]];

endmodule

// File: tb/tb_if_id_fifo.sv
// Bench for if_id_fifo: reference queue model checked every cycle, a vector table
// for fill/hold/drain, and directed sequences for reset, flush, wrap and full-with-pop.
module tb_if_id_fifo;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_i;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic        ready_i;
    logic [2:0]  count_o;

    if_id_fifo #(.AW(32), .IW(32), .DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_addr_i (inst_addr_i),
        .inst_i      (inst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .flush_i     (flush_i),
        .inst_addr_o (inst_addr_o),
        .inst_o      (inst_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
    } pair_t;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] i;
        logic        r;
        logic        f;
        logic        exp_valid;
        logic        exp_ready;
        int          exp_count;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
    } vec_t;

    pair_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Compare DUT outputs against the reference queue state.
    task automatic check_model(input string tag);
        check({tag, " valid_o"}, 64'(valid_o), 64'(sb.size() != 0));
        check({tag, " count_o"}, 64'(count_o), 64'(sb.size()));
        check({tag, " ready_o"}, 64'(ready_o), 64'(sb.size() < DEPTH));
        if (sb.size() != 0) begin
            check({tag, " head addr"}, 64'(inst_addr_o), 64'(sb[0].addr));
            check({tag, " head inst"}, 64'(inst_o), 64'(sb[0].inst));
        end else begin
            check({tag, " empty addr"}, 64'(inst_addr_o), 64'h0);
            check({tag, " empty inst"}, 64'(inst_o), 64'(NOP));
        end
    endtask

    // One clock: check current outputs, drive inputs, update model, advance past the edge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] ins,
                         input logic r, input logic f);
        pair_t p;
        bit    do_push;
        bit    do_pop;
        check_model("pre");
        valid_i     = v;
        inst_addr_i = a;
        inst_i      = ins;
        ready_i     = r;
        flush_i     = f;
        do_push = v && (sb.size() < DEPTH) && !f;
        do_pop  = (sb.size() != 0) && r && !f;
        if (f) sb.delete();
        else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                p.addr = a;
                p.inst = ins;
                sb.push_back(p);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    vec_t tbl[9];

    initial begin
        rst = 1'b0; valid_i = 1'b0; inst_addr_i = '0; inst_i = '0;
        ready_i = 1'b0; flush_i = 1'b0;

        // Reset values
        #1;
        check("reset valid_o", 64'(valid_o), 64'h0);
        check("reset ready_o", 64'(ready_o), 64'h1);
        check("reset count_o", 64'(count_o), 64'h0);
        check("reset inst_o", 64'(inst_o), 64'(NOP));
        check("reset inst_addr_o", 64'(inst_addr_o), 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single pass
        cycle(1'b1, 32'h100, 32'h0050_0093, 1'b1, 1'b0);
        check("single valid", 64'(valid_o), 64'h1);
        check("single addr", 64'(inst_addr_o), 64'h100);
        check("single inst", 64'(inst_o), 64'h0050_0093);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("single drained valid", 64'(valid_o), 64'h0);
        check("single drained inst", 64'(inst_o), 64'(NOP));

        // Fill/hold/drain table: expected outputs after each edge
        tbl[0] = '{1'b1, 32'h100, mk_inst(32'h100), 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h100, mk_inst(32'h100)};
        tbl[1] = '{1'b1, 32'h104, mk_inst(32'h104), 1'b0, 1'b0, 1'b1, 1'b1, 2, 32'h100, mk_inst(32'h100)};
        tbl[2] = '{1'b1, 32'h108, mk_inst(32'h108), 1'b0, 1'b0, 1'b1, 1'b1, 3, 32'h100, mk_inst(32'h100)};
        tbl[3] = '{1'b1, 32'h10C, mk_inst(32'h10C), 1'b0, 1'b0, 1'b1, 1'b0, 4, 32'h100, mk_inst(32'h100)};
        tbl[4] = '{1'b1, 32'h110, mk_inst(32'h110), 1'b0, 1'b0, 1'b1, 1'b0, 4, 32'h100, mk_inst(32'h100)};
        tbl[5] = '{1'b0, 32'h0,   32'h0,            1'b1, 1'b0, 1'b1, 1'b1, 3, 32'h104, mk_inst(32'h104)};
        tbl[6] = '{1'b0, 32'h0,   32'h0,            1'b1, 1'b0, 1'b1, 1'b1, 2, 32'h108, mk_inst(32'h108)};
        tbl[7] = '{1'b0, 32'h0,   32'h0,            1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h10C, mk_inst(32'h10C)};
        tbl[8] = '{1'b0, 32'h0,   32'h0,            1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h0,   NOP};
        for (int k = 0; k < 9; k++) begin
            cycle(tbl[k].v, tbl[k].a, tbl[k].i, tbl[k].r, tbl[k].f);
            check($sformatf("tbl%0d valid", k), 64'(valid_o), 64'(tbl[k].exp_valid));
            check($sformatf("tbl%0d ready", k), 64'(ready_o), 64'(tbl[k].exp_ready));
            check($sformatf("tbl%0d count", k), 64'(count_o), 64'(tbl[k].exp_count));
            check($sformatf("tbl%0d addr", k), 64'(inst_addr_o), 64'(tbl[k].exp_addr));
            check($sformatf("tbl%0d inst", k), 64'(inst_o), 64'(tbl[k].exp_inst));
        end

        // Simultaneous push/pop at count 2 across pointer wrap
        cycle(1'b1, 32'h300, mk_inst(32'h300), 1'b0, 1'b0);
        cycle(1'b1, 32'h304, mk_inst(32'h304), 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 32'h308 + 32'(4 * k), mk_inst(32'h308 + 32'(4 * k)), 1'b1, 1'b0);
            check($sformatf("simul%0d count", k), 64'(count_o), 64'h2);
            check($sformatf("simul%0d addr", k), 64'(inst_addr_o), 64'(32'h304 + 32'(4 * k)));
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with count 3 and a same-cycle push and pop
        cycle(1'b1, 32'h400, mk_inst(32'h400), 1'b0, 1'b0);
        cycle(1'b1, 32'h404, mk_inst(32'h404), 1'b0, 1'b0);
        cycle(1'b1, 32'h408, mk_inst(32'h408), 1'b0, 1'b0);
        check("preflush count", 64'(count_o), 64'h3);
        cycle(1'b1, 32'h3FC, mk_inst(32'h3FC), 1'b1, 1'b1);
        check("flush count", 64'(count_o), 64'h0);
        check("flush valid", 64'(valid_o), 64'h0);
        check("flush inst", 64'(inst_o), 64'(NOP));
        check("flush ready", 64'(ready_o), 64'h1);
        cycle(1'b1, 32'h200, mk_inst(32'h200), 1'b0, 1'b0);
        check("post-flush head", 64'(inst_addr_o), 64'h200);

        // Full with pop: no push while full, accepted the following cycle
        cycle(1'b1, 32'h204, mk_inst(32'h204), 1'b0, 1'b0);
        cycle(1'b1, 32'h208, mk_inst(32'h208), 1'b0, 1'b0);
        cycle(1'b1, 32'h20C, mk_inst(32'h20C), 1'b0, 1'b0);
        check("full count", 64'(count_o), 64'h4);
        cycle(1'b1, 32'h210, mk_inst(32'h210), 1'b1, 1'b0);
        check("full+pop count", 64'(count_o), 64'h3);
        check("full+pop head", 64'(inst_addr_o), 64'h204);
        cycle(1'b1, 32'h210, mk_inst(32'h210), 1'b0, 1'b0);
        check("after full push count", 64'(count_o), 64'h4);
        for (int k = 0; k < 5; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_model("drained");

        // Asynchronous reset mid-run with count 3, no clock edge in between
        cycle(1'b1, 32'h500, mk_inst(32'h500), 1'b0, 1'b0);
        cycle(1'b1, 32'h504, mk_inst(32'h504), 1'b0, 1'b0);
        cycle(1'b1, 32'h508, mk_inst(32'h508), 1'b0, 1'b0);
        check("prereset count", 64'(count_o), 64'h3);
        valid_i = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("async reset valid_o", 64'(valid_o), 64'h0);
        check("async reset inst_o", 64'(inst_o), 64'(NOP));
        check("async reset inst_addr_o", 64'(inst_addr_o), 64'h0);
        check("async reset count_o", 64'(count_o), 64'h0);
        check("async reset ready_o", 64'(ready_o), 64'h1);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        cycle(1'b1, 32'h600, mk_inst(32'h600), 1'b0, 1'b0);
        check_model("post-reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_fifo.md
# if_id_fifo

Parametrised IF/ID decoupling stage sitting between instruction fetch and decode. It replaces the single-entry hold/NOP register with a DEPTH-entry instruction queue carrying (address, instruction) pairs. The queue uses a valid/ready handshake on both sides and a flush input that discards all queued entries on a taken jump. When the queue is empty, decode sees a NOP bubble with address zero.

## Interface
Parameters:
- AW, 32, instruction address width
- IW, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- NOP, 32'h0000_0013, instruction driven when no valid entry (addi x0,x0,0)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- inst_addr_i  input  AW  fetched instruction address
- inst_i  input  IW  fetched instruction word
- valid_i  input  1  fetch presents a valid pair
- ready_o  output  1  queue can accept this cycle
- flush_i  input  1  discard all entries (jump/branch taken)
- inst_addr_o  output  AW  head entry address to decode
- inst_o  output  IW  head entry instruction to decode
- valid_o  output  1  head entry valid
- ready_i  input  1  decode consumes head this cycle (low = hold)
- count_o  output  log2(DEPTH)+1  number of occupied entries

## Operation
- Storage: DEPTH-entry register array, write pointer wp and read pointer rp, each log2(DEPTH)+1 bits. Pointers wrap modulo 2·DEPTH. Index = low log2(DEPTH) bits.
- count_o = wp − rp (modular); full when count_o == DEPTH; empty when count_o == 0.
- push = valid_i & ready_o & ~flush_i; writes {inst_addr_i, inst_i} at wp[idx]; wp+1.
- pop = valid_o & ready_i & ~flush_i; rp+1.
- Push and pop in the same cycle are both performed; count_o is unchanged.
- ready_o = ~full (combinational from registered count). No write-through when full: a pop in a full cycle frees space only from the next cycle.
- valid_o = ~empty.
- inst_o = NOP when empty, else mem[rp].inst. inst_addr_o = 0 when empty, else mem[rp].addr.
- flush_i has priority over everything. At the edge, wp and rp are both set to 0. Any same-cycle push and pop are discarded. Storage contents are don't-care.
- Hold is expressed only through ready_i=0: head and outputs stay stable, and the queue keeps filling until full.
- Reset (rst=0, asynchronous): wp=rp=0 immediately, not waiting for clk. Storage is not reset.

## Timing
- Reset values: valid_o=0, ready_o=1, count_o=0, inst_o=NOP, inst_addr_o=0.
- Latency: a pair accepted at edge N is visible on inst_o/inst_addr_o with valid_o=1 after edge N (in cycle N+1) if the queue was empty. No combinational path exists from inst_i/valid_i to any output.
- After flush at edge N: from cycle N+1, valid_o=0, inst_o=NOP, count_o=0, ready_o=1.
- Reset deassertion is taken synchronously by the integrator. The first push is possible on the first edge with rst=1.
- Order is strict FIFO. Across pointer wrap-around (after 2·DEPTH pushes), order and count_o stay correct.
- Outputs are stable while valid_o=1 and ready_i=0.

## Test plan
- Reset: assert rst=0 mid-run with count_o=3 → outputs go immediately (without clk) to valid_o=0, inst_o=32'h13, inst_addr_o=0, count_o=0, ready_o=1.
- Single pass: push (0x100, 0x00500093) with ready_i=1 → next cycle valid_o=1 with that pair; one cycle later valid_o=0, inst_o=NOP.
- Fill/hold: ready_i=0, push 0x100,0x104,0x108,0x10C → count_o=4, ready_o=0. A fifth push is ignored. Release ready_i → outputs 0x100..0x10C in order, then NOP.
- Simultaneous: count_o=2, push and pop in the same cycle for 10 cycles → count_o stays 2; addresses leave in push order across pointer wrap.
- Flush: count_o=3 with valid_i=1 and ready_i=1 in the flush cycle → next cycle count_o=0, valid_o=0, inst_o=NOP. The same-cycle input does not appear. The next push of 0x200 is the first output.
- Full with pop: count_o=4, ready_i=1, valid_i=1 → no push that cycle (count_o=3 next); push accepted the following cycle.
